// File: rtl/gf2m_pkg.sv
// Shared definitions for the digit-serial GF(2^M) multiplier.
//   state_t    : controller states (IDLE, RUN, DONE)
//   POLY_16    : low 16 bits of x^16 + x^5 + x^3 + x^2 + 1
//   calc_ndig  : number of D-bit digits needed to cover an M-bit operand
package gf2m_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam logic [15:0] POLY_16 = 16'h002D;

    function automatic int calc_ndig(input int m, input int d);
        return (m + d - 1) / d;
    endfunction

endpackage

// File: rtl/gf2m_digit_step.sv
// One Horner iteration of the digit-serial multiplier (purely combinational).
//   z      : running accumulator, already reduced (degree < M)
//   a      : multiplicand, reduced
//   digit  : D bits of the multiplier, MSB first
//   z_next : (z * x^D + a * digit) mod (x^M + POLY), fully reduced
module gf2m_digit_step
    import gf2m_pkg::*;
#(
    parameter int           M    = 16,
    parameter int           D    = 8,
    parameter logic [M-1:0] POLY = M'(POLY_16)
) (
    input  logic [M-1:0] z,
    input  logic [M-1:0] a,
    input  logic [D-1:0] digit,
    output logic [M-1:0] z_next
);

    // Multiply by x and fold the carried-out x^M term back in as POLY.
    function automatic logic [M-1:0] mul_x(input logic [M-1:0] v);
        return {v[M-2:0], 1'b0} ^ (v[M-1] ? POLY : '0);
    endfunction

    logic [M-1:0] z_shift;
    logic [M-1:0] pp;

    always_comb begin
        z_shift = z;
        for (int i = 0; i < D; i++) begin
            z_shift = mul_x(z_shift);
        end
        // a * digit built by its own Horner pass so every intermediate
        // stays below degree M, whatever POLY looks like.
        pp = '0;
        for (int j = D - 1; j >= 0; j--) begin
            pp = mul_x(pp);
            if (digit[j]) begin
                pp = pp ^ a;
            end
        end
        z_next = z_shift ^ pp;
    end

endmodule

// File: rtl/gf2m_digit_serial_mult.sv
// Digit-serial GF(2^M) multiplier / multiply-accumulate with valid/ready
// handshakes on both sides.
//   clk, rst_n          : clock, asynchronous active-low reset
//   in_valid, in_ready  : operand handshake (accepted only in IDLE)
//   mode                : 0 = A*B, 1 = A*B + c_in
//   a_in, b_in, c_in    : operands (c_in ignored when mode = 0)
//   out_valid, out_ready: result handshake (result held in DONE)
//   c_out               : result, holds its value after the handshake
//   busy                : high while digits are being processed
module gf2m_digit_serial_mult
    import gf2m_pkg::*;
#(
    parameter int           M    = 16,
    parameter int           D    = 8,
    parameter logic [M-1:0] POLY = M'(POLY_16)
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic         mode,
    input  logic [M-1:0] a_in,
    input  logic [M-1:0] b_in,
    input  logic [M-1:0] c_in,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [M-1:0] c_out,
    output logic         busy
);

    localparam int NDIG = calc_ndig(M, D);
    localparam int BW   = NDIG * D;
    localparam int CW   = (NDIG > 1) ? $clog2(NDIG) : 1;

    localparam logic [CW-1:0] CNT_LAST = CW'(NDIG - 1);
    localparam logic [CW-1:0] CNT_ONE  = CW'(1);

    state_t        state_q;
    state_t        state_d;
    logic [M-1:0]  a_q;
    logic [BW-1:0] b_q;
    logic [M-1:0]  cacc_q;
    logic [M-1:0]  z_q;
    logic [CW-1:0] cnt_q;
    logic [D-1:0]  digit;
    logic [M-1:0]  z_next;

    // B is zero-padded at the top, so the leading digit may be partly empty.
    assign digit = b_q[int'(cnt_q) * D +: D];

    gf2m_digit_step #(
        .M    (M),
        .D    (D),
        .POLY (POLY)
    ) u_step (
        .z      (z_q),
        .a      (a_q),
        .digit  (digit),
        .z_next (z_next)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (in_valid)       state_d = RUN;
            RUN:     if (cnt_q == '0)    state_d = DONE;
            DONE:    if (out_ready)      state_d = IDLE;
            default:                     state_d = IDLE;
        endcase
    end

    always_comb begin
        in_ready  = 1'b0;
        busy      = 1'b0;
        out_valid = 1'b0;
        case (state_q)
            IDLE:    in_ready  = 1'b1;
            RUN:     busy      = 1'b1;
            DONE:    out_valid = 1'b1;
            default: in_ready  = 1'b0;
        endcase
    end

    // Datapath. Mode is not stored separately: forcing the addend to zero
    // for a plain multiply makes the final XOR a no-op.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_q    <= '0;
            b_q    <= '0;
            cacc_q <= '0;
            z_q    <= '0;
            cnt_q  <= '0;
            c_out  <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (in_valid) begin
                        a_q    <= a_in;
                        b_q    <= BW'(b_in);
                        cacc_q <= mode ? c_in : '0;
                        z_q    <= '0;
                        cnt_q  <= CNT_LAST;
                    end
                end
                RUN: begin
                    z_q   <= z_next;
                    cnt_q <= cnt_q - CNT_ONE;
                    if (cnt_q == '0) begin
                        c_out <= z_next ^ cacc_q;
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_gf2m_digit_serial_mult.sv
// Self-checking bench: four multiplier instances (D = 8, 1, 5, 16, M = 16)
// against a carry-less multiply + polynomial long-division reference.
module tb_gf2m_digit_serial_mult;

    localparam logic [15:0] POLY = 16'h002D;

    logic        clk   = 1'b0;
    logic        rst_n = 1'b1;
    logic        mode  = 1'b0;
    logic [15:0] a     = '0;
    logic [15:0] b     = '0;
    logic [15:0] c     = '0;
    logic [3:0]  iv    = '0;
    logic [3:0]  orr   = '0;
    logic [3:0]  ir;
    logic [3:0]  ov;
    logic [3:0]  bz;
    logic [15:0] co [4];

    int checks   = 0;
    int failures = 0;
    int ndig_t [4] = '{2, 16, 4, 1};

    always #5 clk = ~clk;

    gf2m_digit_serial_mult #(.M(16), .D(8), .POLY(POLY)) u_d8 (
        .clk(clk), .rst_n(rst_n), .in_valid(iv[0]), .in_ready(ir[0]), .mode(mode),
        .a_in(a), .b_in(b), .c_in(c), .out_valid(ov[0]), .out_ready(orr[0]),
        .c_out(co[0]), .busy(bz[0]));

    gf2m_digit_serial_mult #(.M(16), .D(1), .POLY(POLY)) u_d1 (
        .clk(clk), .rst_n(rst_n), .in_valid(iv[1]), .in_ready(ir[1]), .mode(mode),
        .a_in(a), .b_in(b), .c_in(c), .out_valid(ov[1]), .out_ready(orr[1]),
        .c_out(co[1]), .busy(bz[1]));

    gf2m_digit_serial_mult #(.M(16), .D(5), .POLY(POLY)) u_d5 (
        .clk(clk), .rst_n(rst_n), .in_valid(iv[2]), .in_ready(ir[2]), .mode(mode),
        .a_in(a), .b_in(b), .c_in(c), .out_valid(ov[2]), .out_ready(orr[2]),
        .c_out(co[2]), .busy(bz[2]));

    gf2m_digit_serial_mult #(.M(16), .D(16), .POLY(POLY)) u_d16 (
        .clk(clk), .rst_n(rst_n), .in_valid(iv[3]), .in_ready(ir[3]), .mode(mode),
        .a_in(a), .b_in(b), .c_in(c), .out_valid(ov[3]), .out_ready(orr[3]),
        .c_out(co[3]), .busy(bz[3]));

    // Full 31-bit carry-less product, then reduce from the top down.
    function automatic logic [15:0] ref_mul(input logic [15:0] x, input logic [15:0] y,
                                            input logic [15:0] acc, input logic m);
        logic [31:0] p;
        p = '0;
        for (int i = 0; i < 16; i++) begin
            if (y[i]) p = p ^ (32'(x) << i);
        end
        for (int i = 31; i >= 16; i--) begin
            if (p[i]) p = p ^ ((32'h0001_0000 | 32'(POLY)) << (i - 16));
        end
        return p[15:0] ^ (m ? acc : 16'h0000);
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Issue one operation on instance k with out_ready high; returns the
    // result and the number of edges from acceptance to out_valid.
    task automatic do_op(input int k, input logic [15:0] xa, input logic [15:0] xb,
                         input logic [15:0] xc, input logic xm,
                         output logic [15:0] res, output int lat);
        @(negedge clk);
        chk($sformatf("in_ready_idle_%0d", k), 32'(ir[k]), 32'd1);
        a = xa; b = xb; c = xc; mode = xm;
        iv[k] = 1'b1;
        @(posedge clk);
        #1;
        iv[k] = 1'b0;
        lat = 0;
        while (ov[k] !== 1'b1 && lat < 64) begin
            @(posedge clk);
            #1;
            lat++;
        end
        res = co[k];
        // out_ready is high, so DONE ends at the next edge.
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic [15:0] res;
        logic [15:0] held;
        logic [15:0] ra, rb, rc;
        logic        rm;
        int          lat;

        // Reset state
        #2 rst_n = 1'b0;
        #1;
        chk("rst_in_ready", 32'(ir[0]), 32'd1);
        chk("rst_out_valid", 32'(ov[0]), 32'd0);
        chk("rst_busy", 32'(bz[0]), 32'd0);
        chk("rst_c_out", 32'(co[0]), 32'd0);
        orr = 4'hF;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;

        // Directed vectors on the default instance
        do_op(0, 16'h8421, 16'h0002, 16'h0000, 1'b0, res, lat);
        chk("mul_8421x2", 32'(res), 32'h086F);
        chk("lat_default", 32'(lat), 32'd2);
        do_op(0, 16'h1234, 16'h0002, 16'h0001, 1'b1, res, lat);
        chk("mac_1234x2_p1", 32'(res), 32'h2469);
        do_op(0, 16'h1234, 16'h0002, 16'hFFFF, 1'b0, res, lat);
        chk("mul_cin_ignored", 32'(res), 32'h2468);
        do_op(0, 16'h8000, 16'h8000, 16'h0000, 1'b0, res, lat);
        chk("mul_8000x8000", 32'(res), 32'h411F);
        do_op(0, 16'hFFFF, 16'h0001, 16'h0000, 1'b0, res, lat);
        chk("mul_ffffx1", 32'(res), 32'hFFFF);

        // Backpressure
        orr[0] = 1'b0;
        @(negedge clk);
        a = 16'hBEEF; b = 16'h1357; c = 16'h0F0F; mode = 1'b1;
        iv[0] = 1'b1;
        @(posedge clk);
        #1;
        iv[0] = 1'b0;
        lat = 0;
        while (ov[0] !== 1'b1 && lat < 64) begin
            @(posedge clk);
            #1;
            lat++;
        end
        chk("bp_out_valid", 32'(ov[0]), 32'd1);
        held = co[0];
        chk("bp_result", 32'(held), 32'(ref_mul(16'hBEEF, 16'h1357, 16'h0F0F, 1'b1)));
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            a = 16'($urandom); b = 16'($urandom);
            iv[0] = 1'b1;
            @(posedge clk);
            #1;
            chk($sformatf("bp_hold_valid_%0d", i), 32'(ov[0]), 32'd1);
            chk($sformatf("bp_hold_cout_%0d", i), 32'(co[0]), 32'(held));
            chk($sformatf("bp_in_ready_%0d", i), 32'(ir[0]), 32'd0);
            chk($sformatf("bp_not_busy_%0d", i), 32'(bz[0]), 32'd0);
        end
        @(negedge clk);
        orr[0] = 1'b1;
        @(posedge clk);
        #1;
        iv[0] = 1'b0;
        chk("bp_release_valid", 32'(ov[0]), 32'd0);
        chk("bp_release_ready", 32'(ir[0]), 32'd1);
        chk("bp_release_busy", 32'(bz[0]), 32'd0);
        chk("bp_release_cout", 32'(co[0]), 32'(held));

        // Reset mid-multiply on the bit-serial instance
        do_op(1, 16'h1234, 16'h5678, 16'h0000, 1'b0, res, lat);
        chk("pre_rst_result", 32'(res), 32'(ref_mul(16'h1234, 16'h5678, 16'h0, 1'b0)));
        @(negedge clk);
        a = 16'hA5A5; b = 16'h5A5A; mode = 1'b0;
        iv[1] = 1'b1;
        @(posedge clk);
        #1;
        iv[1] = 1'b0;
        repeat (5) @(posedge clk);
        #1;
        chk("mid_busy", 32'(bz[1]), 32'd1);
        #2 rst_n = 1'b0;
        #1;
        chk("arst_c_out", 32'(co[1]), 32'd0);
        chk("arst_out_valid", 32'(ov[1]), 32'd0);
        chk("arst_busy", 32'(bz[1]), 32'd0);
        chk("arst_in_ready", 32'(ir[1]), 32'd1);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (20) @(posedge clk);
        #1;
        chk("arst_no_result_valid", 32'(ov[1]), 32'd0);
        chk("arst_no_result_cout", 32'(co[1]), 32'd0);
        do_op(0, 16'h0001, 16'h0001, 16'h0000, 1'b0, res, lat);
        chk("post_rst_1x1", 32'(res), 32'h0001);

        // Random sweep across digit sizes
        for (int k = 0; k < 4; k++) begin
            for (int n = 0; n < 6; n++) begin
                ra = 16'($urandom);
                rb = 16'($urandom);
                rc = 16'($urandom);
                rm = 1'($urandom);
                do_op(k, ra, rb, rc, rm, res, lat);
                chk($sformatf("rand_k%0d_n%0d", k, n), 32'(res), 32'(ref_mul(ra, rb, rc, rm)));
                chk($sformatf("lat_k%0d_n%0d", k, n), 32'(lat), 32'(ndig_t[k]));
            end
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
